input_manager: RTL and testbench



---
 rtl/tetris_pkg.sv | 11 +
 rtl/das_channel.sv | 64 ++++++
 rtl/input_manager.sv | 75 +++++++
 tb/tb_input_manager.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared constants for the Tetris front-end blocks.
// DAS_DELAY_DEF : frames a movement key is held before it first auto-repeats.
// DAS_SPEED_DEF : frames between auto-repeats once repeating.
// TIMER_W_DEF   : width of a per-key frame counter. It must be able to hold DAS_DELAY.
package tetris_pkg;

  localparam int DAS_DELAY_DEF = 16;
  localparam int DAS_SPEED_DEF = 4;
  localparam int TIMER_W_DEF   = 8;

endpackage

// File: rtl/das_channel.sv
// One delayed-auto-shift channel for a single movement key.
// Ports:
//   clk_sys_i   : system clock
//   rst_i       : synchronous active-high reset
//   tick_game_i : one-cycle frame pulse that paces the repeats
//   raw_i       : held-button level
//   cmd_o       : registered one-cycle command. It pulses once on press, then auto-repeats.
module das_channel
  import tetris_pkg::*;
#(
  parameter int DAS_DELAY = DAS_DELAY_DEF,
  parameter int DAS_SPEED = DAS_SPEED_DEF,
  parameter int TIMER_W   = TIMER_W_DEF
) (
  input  logic clk_sys_i,
  input  logic rst_i,
  input  logic tick_game_i,
  input  logic raw_i,
  output logic cmd_o
);

  localparam logic [TIMER_W-1:0] DELAY_C  = TIMER_W'(DAS_DELAY);
  // Once the delay has been reached, the timer reloads so that the next
  // DAS_SPEED counted ticks bring it back to DELAY_C.
  localparam logic [TIMER_W-1:0] RELOAD_C = TIMER_W'(DAS_DELAY - DAS_SPEED + 1);

  logic               s1_q, s2_q, s3_q;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               cmd_q, cmd_d;
  logic               press, fire;

  // s2 is the held level. The edge of s2 against s3 marks a new press.
  assign press = s2_q & ~s3_q;
  assign fire  = tick_game_i & s2_q & (timer_q == DELAY_C);

  always_comb begin
    timer_d = timer_q;
    cmd_d   = press | fire;
    if (!s2_q) begin
      timer_d = '0;
    end else if (tick_game_i) begin
      timer_d = (timer_q == DELAY_C) ? RELOAD_C : timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      timer_q <= '0;
      cmd_q   <= 1'b0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      timer_q <= timer_d;
      cmd_q   <= cmd_d;
    end
  end

  assign cmd_o = cmd_q;

endmodule

// File: rtl/input_manager.sv
// Turns debounced button levels into single-cycle game commands.
// Rotate and drop are one-shot keys. Left, right and down pulse once on press
// and then auto-repeat, paced by tick_game_i.
// Ports:
//   clk_sys_i, rst_i       : clock and synchronous active-high reset
//   tick_game_i            : one-cycle frame pulse
//   raw_*_i                : held-button levels
//   cmd_*_o                : registered one-cycle commands to the game FSM
module input_manager
  import tetris_pkg::*;
#(
  parameter int DAS_DELAY = DAS_DELAY_DEF,
  parameter int DAS_SPEED = DAS_SPEED_DEF,
  parameter int TIMER_W   = TIMER_W_DEF
) (
  input  logic clk_sys_i,
  input  logic rst_i,
  input  logic tick_game_i,
  input  logic raw_left_i,
  input  logic raw_right_i,
  input  logic raw_down_i,
  input  logic raw_rotate_i,
  input  logic raw_drop_i,
  output logic cmd_left_o,
  output logic cmd_right_o,
  output logic cmd_down_o,
  output logic cmd_rotate_o,
  output logic cmd_drop_o
);

  logic rot_prev_q, rot_cmd_q;
  logic drop_prev_q, drop_cmd_q;

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      rot_prev_q  <= 1'b0;
      rot_cmd_q   <= 1'b0;
      drop_prev_q <= 1'b0;
      drop_cmd_q  <= 1'b0;
    end else begin
      rot_prev_q  <= raw_rotate_i;
      rot_cmd_q   <= raw_rotate_i & ~rot_prev_q;
      drop_prev_q <= raw_drop_i;
      drop_cmd_q  <= raw_drop_i & ~drop_prev_q;
    end
  end

  assign cmd_rotate_o = rot_cmd_q;
  assign cmd_drop_o   = drop_cmd_q;

  das_channel #(.DAS_DELAY(DAS_DELAY), .DAS_SPEED(DAS_SPEED), .TIMER_W(TIMER_W)) u_das_left (
    .clk_sys_i   (clk_sys_i),
    .rst_i       (rst_i),
    .tick_game_i (tick_game_i),
    .raw_i       (raw_left_i),
    .cmd_o       (cmd_left_o)
  );

  das_channel #(.DAS_DELAY(DAS_DELAY), .DAS_SPEED(DAS_SPEED), .TIMER_W(TIMER_W)) u_das_right (
    .clk_sys_i   (clk_sys_i),
    .rst_i       (rst_i),
    .tick_game_i (tick_game_i),
    .raw_i       (raw_right_i),
    .cmd_o       (cmd_right_o)
  );

  das_channel #(.DAS_DELAY(DAS_DELAY), .DAS_SPEED(DAS_SPEED), .TIMER_W(TIMER_W)) u_das_down (
    .clk_sys_i   (clk_sys_i),
    .rst_i       (rst_i),
    .tick_game_i (tick_game_i),
    .raw_i       (raw_down_i),
    .cmd_o       (cmd_down_o)
  );

endmodule

// File: tb/tb_input_manager.sv
// Self-checking bench for input_manager. It combines a directed vector table,
// hand-written multi-cycle sequences and random stimulus. All of these are
// checked against a history-based reference model.
// Bit order of the 5-bit vectors: {drop, rotate, down, right, left}.
module tb_input_manager;

  localparam int D    = 16;
  localparam int S    = 4;
  localparam int MAXE = 8192;

  logic clk_sys = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  logic [4:0] raw = '0;
  logic [4:0] act;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_sys = ~clk_sys;

  input_manager #(.DAS_DELAY(D), .DAS_SPEED(S), .TIMER_W(8)) dut (
    .clk_sys_i    (clk_sys),
    .rst_i        (rst),
    .tick_game_i  (tick),
    .raw_left_i   (raw[0]),
    .raw_right_i  (raw[1]),
    .raw_down_i   (raw[2]),
    .raw_rotate_i (raw[3]),
    .raw_drop_i   (raw[4]),
    .cmd_left_o   (act[0]),
    .cmd_right_o  (act[1]),
    .cmd_down_o   (act[2]),
    .cmd_rotate_o (act[3]),
    .cmd_drop_o   (act[4])
  );

  // Reference model: it remembers every sampled raw value by edge index, and
  // anything at or before the latest reset edge reads as 0.
  bit   hist [5][MAXE];
  int   edge_n   = 0;
  int   rst_edge = -1;
  int   cnt [3];          // counted ticks while the key is seen held
  logic [4:0] exp_v;

  function automatic bit raw_at(int ch, int k);
    if (k < 0 || k <= rst_edge) return 1'b0;
    return hist[ch][k];
  endfunction

  task automatic check(string name, logic a, logic e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s edge=%0d actual=%b required=%b", name, edge_n, a, e);
    end
  endtask

  task automatic step();
    string nm [5] = '{"cmd_left", "cmd_right", "cmd_down", "cmd_rotate", "cmd_drop"};
    @(posedge clk_sys);
    edge_n++;
    for (int c = 0; c < 5; c++) hist[c][edge_n] = raw[c];
    exp_v = '0;
    if (rst) begin
      rst_edge = edge_n;
      for (int c = 0; c < 3; c++) cnt[c] = 0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        bit lvl, old;
        bit fire;
        lvl  = raw_at(c, edge_n - 2);
        old  = raw_at(c, edge_n - 3);
        fire = tick && lvl && cnt[c] >= D && ((cnt[c] - D) % S) == 0;
        exp_v[c] = (lvl && !old) || fire;
        if (!lvl) cnt[c] = 0;
        else if (tick) cnt[c]++;
      end
      for (int c = 3; c < 5; c++)
        exp_v[c] = raw_at(c, edge_n) && !raw_at(c, edge_n - 1);
    end
    #1;
    for (int c = 0; c < 5; c++) check(nm[c], act[c], exp_v[c]);
  endtask

  typedef struct {
    logic       rst;
    logic       tick;
    logic [4:0] raw;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int k;
    int waited;
    bit seen;

    tbl[0] = '{1'b1, 1'b0, 5'b00000, 5'b00000};
    tbl[1] = '{1'b0, 1'b0, 5'b01001, 5'b01000};
    tbl[2] = '{1'b0, 1'b1, 5'b01001, 5'b00000};
    tbl[3] = '{1'b0, 1'b0, 5'b01001, 5'b00001};
    tbl[4] = '{1'b0, 1'b1, 5'b01001, 5'b00000};
    tbl[5] = '{1'b0, 1'b0, 5'b00001, 5'b00000};
    tbl[6] = '{1'b0, 1'b0, 5'b01001, 5'b01000};
    tbl[7] = '{1'b0, 1'b0, 5'b11001, 5'b10000};
    tbl[8] = '{1'b0, 1'b0, 5'b10001, 5'b00000};

    // Reset state first, then the vector table.
    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst; tick = tbl[i].tick; raw = tbl[i].raw;
      step();
      check($sformatf("tbl%0d", i), (act == tbl[i].exp), 1'b1);
    end

    // Release everything and let the pipeline drain.
    raw = '0; tick = 0;
    repeat (4) step();

    // Rotate is held for 12 cycles and must pulse only once.
    raw[3] = 1;
    k = 0;
    repeat (12) begin step(); if (act[3]) k++; end
    check("rot_once", (k == 1), 1'b1);
    raw[3] = 0; step();
    raw[3] = 1; step();
    check("rot_repress", act[3], 1'b1);
    raw[3] = 0; step();

    // Left DAS timing: the first repeat comes on counted tick 17, then every 4th tick.
    raw[0] = 1;
    repeat (3) step();
    check("left_init", act[0], 1'b1);
    for (int t = 1; t <= 29; t++) begin
      tick = 1; step();
      check($sformatf("das_t%0d", t), act[0], (t >= 17 && (t - 17) % 4 == 0));
      tick = 0; step();
      check("das_gap", act[0], 1'b0);
    end

    // Release and re-press. The timer must start again from zero.
    raw[0] = 0; repeat (3) step();
    raw[0] = 1; repeat (3) step();
    check("repress_init", act[0], 1'b1);
    for (int t = 1; t <= 17; t++) begin
      tick = 1; step();
      check($sformatf("repress_t%0d", t), act[0], (t == 17));
      tick = 0; step();
    end
    raw[0] = 0; repeat (3) step();

    // Drop and down pressed together.
    raw[4] = 1; raw[2] = 1;
    step(); check("drop_lat1", act[4], 1'b1);
    step(); check("drop_w1", act[4], 1'b0);
    step(); check("down_lat3", act[2], 1'b1);
    for (int t = 1; t <= 21; t++) begin
      tick = 1; step();
      check($sformatf("down_t%0d", t), act[2], (t == 17 || t == 21));
      tick = 0; step();
    end
    raw = '0; repeat (4) step();

    // Reset while right is held with its timer at the delay value.
    raw[1] = 1; repeat (3) step();
    waited = 0;
    while (cnt[1] != D && waited < 100) begin
      tick = 1; step(); tick = 0; step(); waited++;
    end
    check("right_reach16", (cnt[1] == D), 1'b1);
    rst = 1; tick = 1; step(); tick = 0;
    check("rst_all0", (act == 5'b0), 1'b1);
    rst = 0;
    k = 0; seen = 0;
    while (!seen && k < 10) begin step(); k++; seen = act[1]; end
    check("rst_refire3", (seen && k == 3), 1'b1);
    raw = '0; repeat (4) step();

    // Random stimulus. Keys are held for long stretches so that repeats occur.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 5; c++)
        if ($urandom_range(0, 15) == 0) raw[c] = ~raw[c];
      tick = ($urandom_range(0, 2) == 0);
      rst  = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
